dso_capture_mc: RTL

DSO_CAPTURE_MC -- requirements
Module: dso_capture_mc

---
 rtl/dso_capture_mc.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dso_capture_mc.sv
// dso_capture_mc
//   Multi-channel oscilloscope capture engine. ADC strobes are decimated,
//   written into one circular buffer per channel, and a trigger FSM freezes a
//   frame made of pre-trigger history and post-trigger samples. The host reads
//   the frame back by logical index, where index 0 is the oldest sample.
//
// Ports
//   clk, rst        single clock (rising edge), asynchronous active-high reset
//   ad_valid        one-cycle sample strobe
//   ad_data         CH_NUM packed samples, channel k in [k*DATA_W +: DATA_W]
//   run             capture enable; low returns to IDLE from any state
//   mode            0 normal, 1 single, 2 auto, 3 behaves as normal
//   trig_ch         trigger channel; values >= CH_NUM fall back to channel 0
//   trig_level      trigger threshold
//   trig_edge       0 rising, 1 falling
//   pre_trig        number of pre-trigger samples in the frame
//   deci_rate       keep one strobe out of deci_rate (0 and 1 keep all)
//   rd_release      pulse: host is finished with the current frame
//   rd_ch, rd_addr  readout channel and logical index
//   rd_data         readout data, one cycle after rd_ch/rd_addr
//   frame_ready     a complete frame is held in DONE
//   frame_done      one-cycle pulse on entry to DONE
//   timeout_flag    the current frame was forced by the auto-mode timeout
//   state           FSM state: IDLE 0, PRE 1, ARMED 2, POST 3, DONE 4
module dso_capture_mc #(
  parameter int CH_NUM  = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int AUTO_TO = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ad_valid,
  input  logic [CH_NUM*DATA_W-1:0] ad_data,
  input  logic                     run,
  input  logic [1:0]               mode,
  input  logic [2:0]               trig_ch,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_edge,
  input  logic [ADDR_W-1:0]        pre_trig,
  input  logic [9:0]               deci_rate,
  input  logic                     rd_release,
  input  logic [2:0]               rd_ch,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     frame_ready,
  output logic                     frame_done,
  output logic                     timeout_flag,
  output logic [2:0]               state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = (AUTO_TO < 2) ? 1 : $clog2(AUTO_TO + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(AUTO_TO);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

  // One wide word per address holds every channel, since all channels are
  // always written together.
  logic [CH_NUM*DATA_W-1:0] mem [DEPTH];

  logic [2:0]               state_q;
  logic [ADDR_W-1:0]        wr_ptr, start_ptr, pre_len, rd_idx;
  logic [ADDR_W:0]          cnt, cnt_inc, post_len;
  logic [9:0]               deci_cnt, deci_lim;
  logic [TO_W-1:0]          to_cnt;
  logic [CH_NUM*DATA_W-1:0] prev_data, rd_word;
  logic [DATA_W-1:0]        cur_trig, prev_trig, rd_sel;
  logic                     prev_valid, single_lock;
  logic                     deci_valid, capturing, wr_en;
  logic                     rise, fall, real_trig, auto_fire, fire;

  assign state    = state_q;
  assign deci_lim = (deci_rate == 10'd0) ? 10'd0 : deci_rate - 10'd1;
  // >= rather than == so a live decrease of deci_rate cannot strand the count.
  assign deci_valid = ad_valid && (deci_cnt >= deci_lim);
  // pre_trig is ADDR_W wide, so it can never exceed DEPTH-1 and needs no clamp.
  assign post_len = DEPTH_V - {1'b0, pre_len};
  assign cnt_inc  = cnt + (ADDR_W + 1)'(1);

  // Once the post count is complete, POST stops writing so the frame is not
  // overwritten during the cycle before DONE.
  assign capturing = (state_q == S_PRE) || (state_q == S_ARMED) ||
                     ((state_q == S_POST) && (cnt < post_len));
  assign wr_en = run && deci_valid && capturing;

  // prev_data keeps every channel, so a live trig_ch change compares
  // against the previous sample of the newly selected channel.
  always_comb begin
    cur_trig  = ad_data[DATA_W-1:0];
    prev_trig = prev_data[DATA_W-1:0];
    for (int k = 1; k < CH_NUM; k++) begin
      if (trig_ch == 3'(k)) begin
        cur_trig  = ad_data[k*DATA_W +: DATA_W];
        prev_trig = prev_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign rise      = (prev_trig < trig_level) && (cur_trig >= trig_level);
  assign fall      = (prev_trig > trig_level) && (cur_trig <= trig_level);
  assign real_trig = prev_valid && (trig_edge ? fall : rise);
  assign auto_fire = (mode == 2'd2) && (to_cnt >= TO_MAX);
  assign fire      = (state_q == S_ARMED) && wr_en && (real_trig || auto_fire);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= ad_data;
    end
  end

  assign rd_idx  = start_ptr + rd_addr;
  assign rd_word = mem[rd_idx];

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (rd_ch == 3'(k)) begin
        rd_sel = rd_word[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel;
    end
  end

  // single_lock blocks re-arming after a single-mode frame until run drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_ready  <= 1'b0;
      frame_done   <= 1'b0;
      timeout_flag <= 1'b0;
      wr_ptr       <= '0;
      start_ptr    <= '0;
      pre_len      <= '0;
      cnt          <= '0;
      deci_cnt     <= '0;
      to_cnt       <= '0;
      prev_data    <= '0;
      prev_valid   <= 1'b0;
      single_lock  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (ad_valid) begin
        deci_cnt <= deci_valid ? 10'd0 : deci_cnt + 10'd1;
      end
      if (!run) begin
        single_lock <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        prev_data  <= ad_data;
        prev_valid <= 1'b1;
      end

      if ((state_q != S_IDLE) && !run) begin
        state_q     <= S_IDLE;
        frame_ready <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run && !single_lock) begin
              state_q      <= S_PRE;
              deci_cnt     <= '0;
              pre_len      <= pre_trig;
              cnt          <= '0;
              prev_valid   <= 1'b0;
              timeout_flag <= 1'b0;
            end
          end
          S_PRE: begin
            if (pre_len == '0) begin
              state_q <= S_ARMED;
              to_cnt  <= '0;
            end else if (wr_en) begin
              cnt <= cnt_inc;
              if (cnt_inc >= {1'b0, pre_len}) begin
                state_q <= S_ARMED;
                to_cnt  <= '0;
              end
            end
          end
          S_ARMED: begin
            // The triggering sample is itself the first post sample.
            if (fire) begin
              state_q      <= S_POST;
              cnt          <= (ADDR_W + 1)'(1);
              start_ptr    <= wr_ptr - pre_len;
              timeout_flag <= !real_trig;
            end else if (to_cnt < TO_MAX) begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          S_POST: begin
            if (cnt >= post_len) begin
              state_q     <= S_DONE;
              frame_done  <= 1'b1;
              frame_ready <= 1'b1;
            end else if (wr_en) begin
              cnt <= cnt_inc;
              if (cnt_inc >= post_len) begin
                state_q     <= S_DONE;
                frame_done  <= 1'b1;
                frame_ready <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (rd_release) begin
              frame_ready <= 1'b0;
              if (mode == 2'd1) begin
                state_q     <= S_IDLE;
                single_lock <= 1'b1;
              end else begin
                state_q      <= S_PRE;
                pre_len      <= pre_trig;
                cnt          <= '0;
                prev_valid   <= 1'b0;
                timeout_flag <= 1'b0;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
